// File: rtl/saturn_bus_ctrl.sv
// Nibble-serial HP48 bus controller: turns core requests into command/address/data nibbles.
// Optional trace output: define SATURN_BUS_DEBUG_EN.
//
// state       | meaning
// S_IDLE      | nothing to drive this bus cycle
// S_SEND_CMD  | drive cmd_q as a command nibble
// S_SEND_ADDR | drive the next address nibble (cnt_q = 0..4, LSB first)
// S_XFER      | one data nibble: DP_WRITE payload or PC_READ strobe
module saturn_bus_ctrl (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_cycle_ctr,
   input  logic        i_en_bus_send,
   input  logic        i_en_bus_recv,
   input  logic        i_en_bus_ecmd,
   input  logic        i_stalled,
   input  logic        i_read_stall,
   output logic        o_stalled_by_bus,
   input  logic [3:0]  i_bus_data,
   output logic [3:0]  o_bus_data,
   output logic        o_bus_strobe,
   output logic        o_bus_cmd_data,
   input  logic [19:0] i_alu_pc,
   input  logic [19:0] i_address,
   input  logic        i_load_pc,
   input  logic        i_cmd_load_dp,
   input  logic        i_read_pc,
   input  logic        i_cmd_dp_write,
   input  logic        i_cmd_reset,
   input  logic        i_cmd_config,
   input  logic [3:0]  i_nibble,
   output logic [3:0]  o_nibble
);
   typedef enum logic [1:0] {S_IDLE, S_SEND_CMD, S_SEND_ADDR, S_XFER} state_t;

   localparam logic [3:0] CMD_PC_READ   = 4'h0;
   localparam logic [3:0] CMD_DP_WRITE  = 4'h3;
   localparam logic [3:0] CMD_LOAD_PC   = 4'h4;
   localparam logic [3:0] CMD_LOAD_DP   = 4'h5;
   localparam logic [3:0] CMD_CONFIGURE = 4'h6;
   localparam logic [3:0] CMD_RESET     = 4'h8;
   localparam logic [3:0] MODE_NONE     = 4'hF;

   state_t      state_q;
   logic [3:0]  cmd_q, mode_q, data_q, bus_data_q, nibble_q;
   logic [19:0] addr_q;
   logic [2:0]  cnt_q;
   logic        boot_q, stall_q, strobe_q, cmd_data_q;

   logic        req_valid_d, req_skip_cmd_d;
   logic [3:0]  req_cmd_d, req_data_d;

   // Request arbitration; only acted on at an ecmd edge while not stalled by the bus.
   always_comb begin
      req_valid_d    = 1'b1;
      req_skip_cmd_d = 1'b0;
      req_cmd_d      = CMD_RESET;
      req_data_d     = i_nibble;
      if (i_cmd_reset)
         req_cmd_d = CMD_RESET;
      else if (i_cmd_config)
         req_cmd_d = CMD_CONFIGURE;
      else if (i_load_pc)
         req_cmd_d = CMD_LOAD_PC;
      else if (i_cmd_load_dp)
         req_cmd_d = CMD_LOAD_DP;
      else if (i_cmd_dp_write) begin
         req_cmd_d      = CMD_DP_WRITE;
         req_skip_cmd_d = (mode_q == CMD_DP_WRITE);
      end else if ((i_read_pc || mode_q == CMD_PC_READ) && !i_read_stall) begin
         req_cmd_d      = CMD_PC_READ;
         req_data_d     = 4'h0;
         req_skip_cmd_d = (mode_q == CMD_PC_READ);
      end else
         req_valid_d = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q    <= S_SEND_CMD;
         cmd_q      <= CMD_LOAD_PC;
         addr_q     <= i_alu_pc;
         cnt_q      <= 3'd0;
         data_q     <= 4'h0;
         mode_q     <= MODE_NONE;
         boot_q     <= 1'b1;
         stall_q    <= 1'b1;
         strobe_q   <= 1'b0;
         bus_data_q <= 4'h0;
         cmd_data_q <= 1'b0;
         nibble_q   <= 4'h0;
      end else begin
         strobe_q <= 1'b0;
         if (!i_stalled) begin
            if (i_en_bus_send && state_q != S_IDLE) begin
               strobe_q <= 1'b1;
               unique case (state_q)
                  S_SEND_CMD:  begin bus_data_q <= cmd_q;       cmd_data_q <= 1'b1; end
                  S_SEND_ADDR: begin bus_data_q <= addr_q[3:0]; cmd_data_q <= 1'b0; end
                  default:     begin bus_data_q <= data_q;      cmd_data_q <= 1'b0; end
               endcase
            end
            if (i_en_bus_recv && state_q == S_XFER && cmd_q == CMD_PC_READ)
               nibble_q <= i_bus_data;
            if (i_en_bus_ecmd) begin
               if (!stall_q) begin
                  if (req_valid_d) begin
                     cmd_q   <= req_cmd_d;
                     addr_q  <= i_address;
                     data_q  <= req_data_d;
                     state_q <= req_skip_cmd_d ? S_XFER : S_SEND_CMD;
                     stall_q <= !req_skip_cmd_d;
                  end else begin
                     state_q <= S_IDLE;
                     stall_q <= 1'b0;
                  end
               end else begin
                  unique case (state_q)
                     S_SEND_CMD: begin
                        if (cmd_q == CMD_DP_WRITE || cmd_q == CMD_PC_READ) begin
                           mode_q  <= cmd_q;
                           state_q <= S_XFER;
                           stall_q <= 1'b0;
                        end else if (cmd_q == CMD_RESET) begin
                           mode_q  <= MODE_NONE;
                           state_q <= S_IDLE;
                           stall_q <= 1'b0;
                        end else begin
                           mode_q  <= MODE_NONE;
                           state_q <= S_SEND_ADDR;
                           cnt_q   <= 3'd0;
                        end
                     end
                     S_SEND_ADDR: begin
                        addr_q <= {4'h0, addr_q[19:4]};
                        cnt_q  <= cnt_q + 3'd1;
                        if (cnt_q == 3'd4) begin
                           // The post-reset PC load chains straight into the PC_READ command.
                           if (boot_q) begin
                              boot_q  <= 1'b0;
                              state_q <= S_SEND_CMD;
                              cmd_q   <= CMD_PC_READ;
                              data_q  <= 4'h0;
                           end else begin
                              state_q <= S_IDLE;
                              stall_q <= 1'b0;
                           end
                        end
                     end
                     default: begin
                        state_q <= S_IDLE;
                        stall_q <= 1'b0;
                     end
                  endcase
               end
            end
         end
      end
   end

   assign o_stalled_by_bus = stall_q;
   assign o_bus_data       = bus_data_q;
   assign o_bus_strobe     = strobe_q;
   assign o_bus_cmd_data   = cmd_data_q;
   assign o_nibble         = nibble_q;

`ifdef SATURN_BUS_DEBUG_EN
   function automatic string cmd_name(input logic [3:0] c);
      case (c)
         CMD_PC_READ:   return "PC_READ";
         CMD_DP_WRITE:  return "DP_WRITE";
         CMD_LOAD_PC:   return "LOAD_PC";
         CMD_LOAD_DP:   return "LOAD_DP";
         CMD_CONFIGURE: return "CONFIGURE";
         default:       return "RESET";
      endcase
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_reset && !i_stalled) begin
         if (i_en_bus_send && state_q != S_IDLE)
            $display("[%0d] BUS SEND %s %h", i_cycle_ctr,
                     (state_q == S_SEND_CMD) ? "cmd" : "data",
                     (state_q == S_SEND_CMD) ? cmd_q :
                     (state_q == S_SEND_ADDR) ? addr_q[3:0] : data_q);
         if (i_en_bus_recv && state_q == S_XFER && cmd_q == CMD_PC_READ)
            $display("[%0d] BUS RECV data %h", i_cycle_ctr, i_bus_data);
         if (i_en_bus_ecmd && !stall_q && req_valid_d && !req_skip_cmd_d)
            $display("[%0d] BUS %s addr %h", i_cycle_ctr, cmd_name(req_cmd_d), i_address);
      end
   end
`else
   logic unused_cycle_ctr;
   assign unused_cycle_ctr = ^i_cycle_ctr;
`endif

endmodule

// File: tb/tb_saturn_bus_ctrl.sv
// Bench for saturn_bus_ctrl: vector table, hand sequences and a queue-based reference model.
module tb_saturn_bus_ctrl;
   logic        i_clk = 1'b0, i_reset = 1'b0;
   logic [31:0] i_cycle_ctr = 32'd0;
   logic        i_en_bus_send = 1'b0, i_en_bus_recv = 1'b0, i_en_bus_ecmd = 1'b0;
   logic        i_stalled = 1'b0, i_read_stall = 1'b0;
   logic        o_stalled_by_bus, o_bus_strobe, o_bus_cmd_data;
   logic [3:0]  i_bus_data = 4'h0, o_bus_data, i_nibble = 4'h0, o_nibble;
   logic [19:0] i_alu_pc = 20'h0, i_address = 20'h0;
   logic        i_load_pc = 1'b0, i_cmd_load_dp = 1'b0, i_read_pc = 1'b0;
   logic        i_cmd_dp_write = 1'b0, i_cmd_reset = 1'b0, i_cmd_config = 1'b0;

   always #5 i_clk = ~i_clk;

   saturn_bus_ctrl dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_cycle_ctr(i_cycle_ctr),
      .i_en_bus_send(i_en_bus_send), .i_en_bus_recv(i_en_bus_recv), .i_en_bus_ecmd(i_en_bus_ecmd),
      .i_stalled(i_stalled), .i_read_stall(i_read_stall), .o_stalled_by_bus(o_stalled_by_bus),
      .i_bus_data(i_bus_data), .o_bus_data(o_bus_data), .o_bus_strobe(o_bus_strobe),
      .o_bus_cmd_data(o_bus_cmd_data), .i_alu_pc(i_alu_pc), .i_address(i_address),
      .i_load_pc(i_load_pc), .i_cmd_load_dp(i_cmd_load_dp), .i_read_pc(i_read_pc),
      .i_cmd_dp_write(i_cmd_dp_write), .i_cmd_reset(i_cmd_reset), .i_cmd_config(i_cmd_config),
      .i_nibble(i_nibble), .o_nibble(o_nibble)
   );

   int checks = 0, failures = 0;

   // Reference model: the bus transfers still owed, one entry per nibble.
   typedef struct { logic is_cmd; logic [3:0] val; logic stall; logic is_read; } item_t;
   item_t      mq[$];
   int         m_mode = -1;
   logic       m_stall = 1'b1, m_strobe = 1'b0, m_cmd_data = 1'b0;
   logic [3:0] m_data = 4'h0, m_nibble = 4'h0;
   logic [4:0] cap[$];

   typedef struct {
      logic [5:0]  req;   // {reset, config, load_pc, load_dp, dp_write, read_pc}
      logic [19:0] addr;
      logic [3:0]  nib;
      int          n;
      logic        quiet;
      logic [4:0]  exp[8];
   } vec_t;
   vec_t vt[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void push_cmd(input logic [3:0] c);
      mq.push_back('{1'b1, c, 1'b1, 1'b0});
   endfunction

   function automatic void push_addr_seq(input logic [3:0] c, input logic [19:0] a);
      push_cmd(c);
      for (int i = 0; i < 5; i++) mq.push_back('{1'b0, 4'(a >> (4 * i)), 1'b1, 1'b0});
   endfunction

   function automatic void sample_requests();
      if (i_cmd_reset) push_cmd(4'h8);
      else if (i_cmd_config) push_addr_seq(4'h6, i_address);
      else if (i_load_pc) push_addr_seq(4'h4, i_address);
      else if (i_cmd_load_dp) push_addr_seq(4'h5, i_address);
      else if (i_cmd_dp_write) begin
         if (m_mode != 3) push_cmd(4'h3);
         mq.push_back('{1'b0, i_nibble, 1'b0, 1'b0});
      end else if ((i_read_pc || m_mode == 0) && !i_read_stall) begin
         if (m_mode != 0) push_cmd(4'h0);
         mq.push_back('{1'b0, 4'h0, 1'b0, 1'b1});
      end
   endfunction

   function automatic void model_edge();
      logic  was_stall;
      item_t it;
      if (!i_reset) begin
         mq.delete();
         push_addr_seq(4'h4, i_alu_pc);
         push_cmd(4'h0);
         mq.push_back('{1'b0, 4'h0, 1'b0, 1'b1});
         m_mode = -1; m_stall = 1'b1; m_strobe = 1'b0;
         m_data = 4'h0; m_cmd_data = 1'b0; m_nibble = 4'h0;
         return;
      end
      m_strobe = 1'b0;
      if (i_stalled) return;
      if (i_en_bus_send && mq.size() > 0) begin
         m_strobe = 1'b1; m_data = mq[0].val; m_cmd_data = mq[0].is_cmd;
      end
      if (i_en_bus_recv && mq.size() > 0 && mq[0].is_read) m_nibble = i_bus_data;
      if (i_en_bus_ecmd) begin
         was_stall = m_stall;
         if (mq.size() > 0) begin
            it = mq.pop_front();
            if (it.is_cmd) m_mode = (it.val == 4'h0 || it.val == 4'h3) ? int'(it.val) : -1;
         end
         if (!was_stall) sample_requests();
         m_stall = (mq.size() > 0) ? mq[0].stall : 1'b0;
      end
   endfunction

   task automatic clk_step(input bit s, input bit r, input bit e);
      i_en_bus_send = s; i_en_bus_recv = r; i_en_bus_ecmd = e;
      @(posedge i_clk);
      model_edge();
      @(negedge i_clk);
      check("strobe", 32'(o_bus_strobe), 32'(m_strobe));
      check("stall", 32'(o_stalled_by_bus), 32'(m_stall));
      check("bus_data", 32'(o_bus_data), 32'(m_data));
      check("cmd_data", 32'(o_bus_cmd_data), 32'(m_cmd_data));
      check("nibble", 32'(o_nibble), 32'(m_nibble));
      if (o_bus_strobe === 1'b1) cap.push_back({o_bus_cmd_data, o_bus_data});
      if (e) i_cycle_ctr = i_cycle_ctr + 32'd1;
   endtask

   task automatic bus_cycle();
      clk_step(1, 0, 0); clk_step(0, 1, 0); clk_step(0, 0, 0); clk_step(0, 0, 1);
   endtask

   task automatic clear_reqs();
      {i_cmd_reset, i_cmd_config, i_load_pc, i_cmd_load_dp, i_cmd_dp_write, i_read_pc} = 6'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 20 && o_stalled_by_bus; k++) bus_cycle();
      check("wait_idle", 32'(o_stalled_by_bus), 32'd0);
   endtask

   task automatic collect(input string name, input int n);
      for (int k = 0; k < 16 && cap.size() < n; k++) bus_cycle();
      check({name, "_count"}, 32'(cap.size()), 32'(n));
   endtask

   function automatic logic [5:0] capv(input int i);
      if (i < cap.size()) return {1'b0, cap[i]};
      return 6'h3F;
   endfunction

   task automatic check_list(input string name, input int n, input logic [4:0] e[8]);
      for (int i = 0; i < n; i++)
         check($sformatf("%s_%0d", name, i), 32'(capv(i)), 32'({1'b0, e[i]}));
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_strobe"}, 32'(o_bus_strobe), 32'd0);
      check({name, "_stall"}, 32'(o_stalled_by_bus), 32'd1);
      check({name, "_data"}, 32'(o_bus_data), 32'd0);
      check({name, "_cmd"}, 32'(o_bus_cmd_data), 32'd0);
      check({name, "_nibble"}, 32'(o_nibble), 32'd0);
   endtask

   initial begin
      logic [4:0] e8[8];
      logic [3:0] rd[3];
      int r;

      vt[0] = '{6'b001000, 20'h12345, 4'h0, 6, 1'b1, '{5'h14, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h00, 5'h00}};
      vt[1] = '{6'b000001, 20'h00000, 4'h0, 2, 1'b0, '{5'h10, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}};
      vt[2] = '{6'b000010, 20'h00000, 4'h7, 2, 1'b1, '{5'h13, 5'h07, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}};
      vt[3] = '{6'b000010, 20'h00000, 4'h9, 1, 1'b1, '{5'h09, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}};
      vt[4] = '{6'b101000, 20'h55555, 4'h0, 1, 1'b1, '{5'h18, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}};
      vt[5] = '{6'b010000, 20'hABCDE, 4'h0, 6, 1'b1, '{5'h16, 5'h0E, 5'h0D, 5'h0C, 5'h0B, 5'h0A, 5'h00, 5'h00}};
      vt[6] = '{6'b000100, 20'h00F01, 4'h0, 6, 1'b1, '{5'h15, 5'h01, 5'h00, 5'h0F, 5'h00, 5'h00, 5'h00, 5'h00}};
      vt[7] = '{6'b000010, 20'h00000, 4'h0, 2, 1'b1, '{5'h13, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}};
      vt[8] = '{6'b000011, 20'h00000, 4'h5, 1, 1'b1, '{5'h05, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}};

      // Reset and boot: LOAD_PC 00000, then PC_READ command, then reads.
      repeat (2) bus_cycle();
      check_reset_vals("reset");
      i_reset = 1'b1;
      cap.delete();
      repeat (7) bus_cycle();
      check("boot_stall", 32'(o_stalled_by_bus), 32'd0);
      check("boot_count", 32'(cap.size()), 32'd7);
      e8 = '{5'h14, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h10, 5'h00};
      bus_cycle();
      check_list("boot", 8, e8);

      for (int v = 0; v < 9; v++) begin
         wait_idle();
         {i_cmd_reset, i_cmd_config, i_load_pc, i_cmd_load_dp, i_cmd_dp_write, i_read_pc} = vt[v].req;
         i_address = vt[v].addr;
         i_nibble  = vt[v].nib;
         bus_cycle();
         clear_reqs();
         cap.delete();
         collect($sformatf("vec%0d", v), vt[v].n);
         check_list($sformatf("vec%0d", v), vt[v].n, vt[v].exp);
         if (vt[v].quiet) begin
            repeat (2) bus_cycle();
            check($sformatf("vec%0d_quiet", v), 32'(cap.size()), 32'(vt[v].n));
         end
      end

      // Read stream A, B, C, then one read-stall cycle.
      wait_idle();
      i_read_pc = 1'b1; bus_cycle(); i_read_pc = 1'b0;
      cap.delete();
      bus_cycle();
      check("rd_cmd", 32'(capv(0)), 32'h10);
      rd = '{4'hA, 4'hB, 4'hC};
      for (int i = 0; i < 3; i++) begin
         i_bus_data = rd[i];
         bus_cycle();
         check($sformatf("rd_nib%0d", i), 32'(o_nibble), 32'(rd[i]));
      end
      check("rd_strobes", 32'(cap.size()), 32'd4);
      i_read_stall = 1'b1; i_bus_data = 4'hD; bus_cycle();
      check("rd_d", 32'(o_nibble), 32'hD);
      i_read_stall = 1'b0; i_bus_data = 4'hE; bus_cycle();
      check("rd_hold", 32'(o_nibble), 32'hD);
      check("rd_nostrobe", 32'(cap.size()), 32'd5);
      i_bus_data = 4'h1; bus_cycle();
      check("rd_resume", 32'(o_nibble), 32'h1);
      check("rd_resume_strobe", 32'(cap.size()), 32'd6);

      // Freeze mid LOAD_DP for two bus cycles.
      wait_idle();
      i_cmd_load_dp = 1'b1; i_address = 20'h6789A; bus_cycle(); i_cmd_load_dp = 1'b0;
      cap.delete();
      repeat (3) bus_cycle();
      i_stalled = 1'b1;
      repeat (2) bus_cycle();
      check("frz_nostrobe", 32'(cap.size()), 32'd3);
      check("frz_stall", 32'(o_stalled_by_bus), 32'd1);
      i_stalled = 1'b0;
      collect("frz", 6);
      e8 = '{5'h15, 5'h0A, 5'h09, 5'h08, 5'h07, 5'h06, 5'h00, 5'h00};
      check_list("frz", 6, e8);

      // Reset in the middle of CONFIGURE restarts with LOAD_PC of the new PC.
      wait_idle();
      i_cmd_config = 1'b1; i_address = 20'h11111; bus_cycle(); i_cmd_config = 1'b0;
      repeat (2) bus_cycle();
      i_reset = 1'b0; i_alu_pc = 20'h2468A; bus_cycle();
      check_reset_vals("midrst");
      i_reset = 1'b1;
      cap.delete();
      collect("midrst", 8);
      e8 = '{5'h14, 5'h0A, 5'h08, 5'h06, 5'h04, 5'h02, 5'h10, 5'h00};
      check_list("midrst", 8, e8);
      check("midrst_stall", 32'(o_stalled_by_bus), 32'd0);

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         clear_reqs();
         r = $urandom_range(0, 99);
         if (r < 4) i_cmd_reset = 1'b1;
         else if (r < 8) i_cmd_config = 1'b1;
         else if (r < 14) i_load_pc = 1'b1;
         else if (r < 20) i_cmd_load_dp = 1'b1;
         else if (r < 40) i_cmd_dp_write = 1'b1;
         else if (r < 55) i_read_pc = 1'b1;
         if ($urandom_range(0, 9) == 0) i_read_pc = 1'b1;
         i_address    = 20'($urandom());
         i_alu_pc     = 20'($urandom());
         i_nibble     = 4'($urandom());
         i_bus_data   = 4'($urandom());
         i_read_stall = ($urandom_range(0, 5) == 0);
         i_stalled    = ($urandom_range(0, 9) == 0);
         i_reset      = ($urandom_range(0, 79) != 0);
         bus_cycle();
      end
      clear_reqs();
      i_stalled = 1'b0; i_read_stall = 1'b0; i_reset = 1'b1;
      repeat (2) bus_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
